bcd_serial_adder_ctrl: RTL and testbench
========================================

Name: bcd_serial_adder_ctrl

Overview:
- Multi-digit packed-BCD adder controller.
- Shares a single one-digit BCD add/correct stage across DIGITS digit positions, LSD first, one digit per clock.
- Sits between operand sources (switch/register inputs) and 7-segment display decode.
- Owns the start/busy/done handshake, the ripple carry between digits, and invalid-digit flagging.

Parameters:
DIGITS, 4, number of BCD digits per operand (range 1..8)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]
b  input  4*DIGITS  operand B, packed BCD
cin  input  1  carry into digit 0
busy  output  1  high while digits are being processed
done  output  1  one-cycle pulse, result valid
sum  output  4*DIGITS  packed BCD result, held until next accepted start
cout  output  1  carry out of the most significant digit
err  output  1  sticky for the operation; some input digit was >9

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, err=0.
  - Digit index and operand registers are cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge k latches a, b and cin, clears err, index=0, and moves to RUN.
  - RUN: busy=1. Each edge processes digit[index], writes result digit[index], updates the carry register, and increments index.
  - RUN exits to DONE after the edge that processes digit DIGITS-1.
  - DONE: done=1 and busy=0 for exactly one cycle. If start=1 that cycle, the new operation is accepted (back-to-back); otherwise the FSM returns to IDLE.
- Timing:
  - busy is high in cycles k+1 .. k+DIGITS.
  - done is high in cycle k+DIGITS+1.
  - Latency is DIGITS+1 cycles from the start edge to done.
- start while busy is ignored. Operand changes while busy are ignored, because operands are latched.
- Digit arithmetic: t = da + db + c, 5-bit unsigned.
  - t<=9: digit=t, carry=0.
  - 10<=t<=19: digit=t-10, carry=1.
  - t>19 (only possible with an invalid input): digit=9, carry=1 (saturate).
- Invalid digit: if da>9 or db>9, err is set and stays set until the next accepted start. Arithmetic still follows the rules above.
- sum: updated digit-by-digit during RUN; only guaranteed valid from the done cycle on. sum, cout and err hold until the next accepted start.
- cout: the carry register value after digit DIGITS-1.
- Reset asserted mid-RUN: no done pulse. The partial sum is discarded (cleared).

Decomposition:
- Package bcd_pkg:
  - localparams BCD_MAX=9 and BCD_BASE=10
  - typedef bcd_digit_t (logic [3:0])
  - enum ctrl_state_t {IDLE, RUN, DONE}
- Sub-module bcd_digit_add:
  - Combinational; inputs da, db, c_in; outputs digit, c_out, invalid.
  - Implements the digit arithmetic and saturation above.
  - Instantiated once and time-shared by the controller.
- The controller holds the FSM, index counter, operand registers, carry register and result register.

Test Plan:
1. DIGITS=4; a=0x1234, b=0x5678, cin=0, start one cycle -> busy cycles 1..4; done at cycle 5; sum=0x6912, cout=0, err=0.
2. a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1, err=0 (carry ripples through all digits).
3. a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
   - Also issue start in the done cycle with a=0x0005, b=0x0004 -> second done 5 cycles later, sum=0x0009.
4. a=0x000F, b=0x0009, cin=0 -> digit0 t=24 saturates to 9, carry 1; sum=0x0019, cout=0, err=1.
   - A following valid operation clears err.
5. Assert start again at cycle 2 of an operation with different operands -> ignored; the result matches the first operands and exactly one done pulse is produced.
6. Drop rst_n low mid-RUN (cycle 2) -> same-cycle busy=0, sum=0, err=0, no done.
   - After release, a new start completes normally in DIGITS+1 cycles.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder.
package bcd_pkg;

    localparam int unsigned BCD_MAX  = 9;
    localparam int unsigned BCD_BASE = 10;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD add/correct stage; purely combinational, time-shared by the controller.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t da,
    input  bcd_digit_t db,
    input  logic       c_in,
    output bcd_digit_t digit,
    output logic       c_out,
    output logic       invalid
);

    logic [4:0] t;

    always_comb begin
        t     = 5'(da) + 5'(db) + 5'(c_in);
        digit = t[3:0];
        c_out = 1'b0;
        // Sums above 19 only arise from non-BCD inputs; pin the digit at 9.
        if (t > 5'(2 * BCD_BASE - 1)) begin
            digit = 4'(BCD_MAX);
            c_out = 1'b1;
        end else if (t >= 5'(BCD_BASE)) begin
            digit = 4'(t - 5'(BCD_BASE));
            c_out = 1'b1;
        end
    end

    assign invalid = (da > 4'(BCD_MAX)) || (db > 4'(BCD_MAX));

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit packed-BCD adder: one shared digit stage walks the operands LSD first,
// one digit per clock, with start/busy/done handshake and sticky invalid-digit flag.
module bcd_serial_adder_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W    = 4 * DIGITS;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    ctrl_state_t     state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;

    bcd_digit_t da, db, res_digit;
    logic       res_carry, res_invalid;

    always_comb begin
        da = '0;
        db = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                da = a_q[4*i +: 4];
                db = b_q[4*i +: 4];
            end
        end
    end

    bcd_digit_add u_digit_add (
        .da      (da),
        .db      (db),
        .c_in    (carry_q),
        .digit   (res_digit),
        .c_out   (res_carry),
        .invalid (res_invalid)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts start too, giving back-to-back operations.
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDXW'(i)) sum_d[4*i +: 4] = res_digit;
                end
                carry_d = res_carry;
                err_d   = err_q | res_invalid;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = res_carry;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed plus randomized checks of the serial BCD adder against a decimal reference model.
module tb_bcd_serial_adder_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Valid operands: plain decimal addition. Invalid digits: apply the per-digit rule.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                                  output logic [W-1:0] ms, output logic mco, output logic me);
        int     da, db, t, c, d;
        bit     valid;
        longint va, vb, tot, scale;
        valid = 1'b1;
        va = 0; vb = 0; scale = 1;
        ms = '0;
        for (int i = 0; i < DIGITS; i++) begin
            da = int'(ma[4*i +: 4]);
            db = int'(mb[4*i +: 4]);
            if (da > 9 || db > 9) valid = 1'b0;
            va += longint'(da) * scale;
            vb += longint'(db) * scale;
            scale *= 10;
        end
        me = !valid;
        if (valid) begin
            tot = va + vb + longint'(mc);
            mco = (tot >= scale);
            tot = tot % scale;
            for (int i = 0; i < DIGITS; i++) begin
                ms[4*i +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end else begin
            c = int'(mc);
            for (int i = 0; i < DIGITS; i++) begin
                t = int'(ma[4*i +: 4]) + int'(mb[4*i +: 4]) + c;
                if (t <= 9)       begin d = t;      c = 0; end
                else if (t <= 19) begin d = t - 10; c = 1; end
                else              begin d = 9;      c = 1; end
                ms[4*i +: 4] = 4'(d);
            end
            mco = (c != 0);
        end
    endfunction

    // Called at a negedge; the following posedge is the start edge.
    task automatic start_op(input logic [W-1:0] na, input logic [W-1:0] nb, input logic nc);
        a = na; b = nb; cin = nc; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Checks DIGITS busy cycles then the done cycle; optional start/operand poke at cycle inj.
    task automatic run_check(input string tag, input logic [W-1:0] es, input logic eco, input logic ee,
                             input int inj, input logic [W-1:0] ia, input logic [W-1:0] ib);
        for (int c = 1; c <= DIGITS; c++) begin
            @(negedge clk);
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " done_early"}, 32'(done), 32'd0);
            if (c == inj) begin
                a = ia; b = ib; cin = ~cin; start = 1'b1;
            end else if (c == inj + 1) begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " cout"}, 32'(cout), 32'(eco));
        check({tag, " err"}, 32'(err), 32'(ee));
    endtask

    task automatic idle_check(input string tag, input logic [W-1:0] es, input logic ee);
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        check({tag, " sum_hold"}, 32'(sum), 32'(es));
        check({tag, " err_hold"}, 32'(err), 32'(ee));
    endtask

    initial begin
        logic [W-1:0] ra, rb, es;
        logic         rc, eco, ee;

        // Reset state
        @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst cout", 32'(cout), 32'd0);
        check("rst err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain add
        start_op(16'h1234, 16'h5678, 1'b0);
        run_check("t1", 16'h6912, 1'b0, 1'b0, 0, '0, '0);
        idle_check("t1", 16'h6912, 1'b0);

        // Carry ripples through every digit
        start_op(16'h9999, 16'h0001, 1'b0);
        run_check("t2", 16'h0000, 1'b1, 1'b0, 0, '0, '0);
        idle_check("t2", 16'h0000, 1'b0);

        // Carry-in, then back-to-back start in the done cycle
        start_op(16'h0000, 16'h0000, 1'b1);
        run_check("t3a", 16'h0001, 1'b0, 1'b0, 0, '0, '0);
        start_op(16'h0005, 16'h0004, 1'b0);
        run_check("t3b", 16'h0009, 1'b0, 1'b0, 0, '0, '0);
        idle_check("t3b", 16'h0009, 1'b0);

        // Invalid digit saturates and flags err; next valid op clears it
        start_op(16'h000F, 16'h0009, 1'b0);
        run_check("t4a", 16'h0019, 1'b0, 1'b1, 0, '0, '0);
        idle_check("t4a", 16'h0019, 1'b1);
        start_op(16'h0001, 16'h0002, 1'b0);
        run_check("t4b", 16'h0003, 1'b0, 1'b0, 0, '0, '0);
        idle_check("t4b", 16'h0003, 1'b0);

        // Start and operand changes while busy are ignored
        start_op(16'h1111, 16'h2222, 1'b0);
        run_check("t5", 16'h3333, 1'b0, 1'b0, 2, 16'h9999, 16'h9999);
        idle_check("t5", 16'h3333, 1'b0);
        idle_check("t5b", 16'h3333, 1'b0);

        // Reset mid-RUN
        start_op(16'h000F, 16'h0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t6 pre busy", 32'(busy), 32'd1);
        check("t6 pre err", 32'(err), 32'd1);
        check("t6 pre sum", 32'(sum), 32'h0005);
        rst_n = 1'b0;
        #1;
        check("t6 busy", 32'(busy), 32'd0);
        check("t6 sum", 32'(sum), 32'd0);
        check("t6 err", 32'(err), 32'd0);
        check("t6 done", 32'(done), 32'd0);
        for (int i = 0; i < DIGITS + 2; i++) begin
            @(negedge clk);
            check("t6 no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        start_op(16'h4321, 16'h1234, 1'b1);
        run_check("t6 post", 16'h5556, 1'b0, 1'b0, 0, '0, '0);
        idle_check("t6 post", 16'h5556, 1'b0);

        // Randomized operands, alternating back-to-back and idle gaps
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < DIGITS; i++) begin
                ra[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
                rb[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            end
            rc = 1'($urandom_range(0, 1));
            model(ra, rb, rc, es, eco, ee);
            start_op(ra, rb, rc);
            run_check("rnd", es, eco, ee, 0, '0, '0);
            if (n % 2 == 0) idle_check("rnd", es, ee);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
